p_lpf_iir: RTL and testbench
============================

Name: p_lpf_iir

Overview:
- Downstream stage of the three-phase active-power calculator.
- Consumes the single-precision instantaneous power sample and its done strobe.
- Produces a first-order low-pass-filtered power: y[n] = y[n-1] + K*(P[n] - y[n-1]).
- The recurrence is evaluated by a sequencing FSM around one shared float adder and one float multiplier.
- Output feeds the controller's power-reference comparison.

Parameters:
- K_COEF, 32'h3D4CCCCD (0.05), IEEE-754 single filter coefficient K.
- Y_INIT, 32'h00000000 (0.0), filter state value after reset or clear.
- ADD_LAT, 7, pipeline latency of the float adder core in cycles.
- MUL_LAT, 5, pipeline latency of the float multiplier core in cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- sta  in  1  one-cycle strobe; P is valid in the same cycle.
- clr  in  1  synchronous clear of the filter state to Y_INIT; honoured only in IDLE.
- P  in  `SINGLE  instantaneous power sample.
- P_filt  out  `SINGLE  filtered power y[n]; held between updates.
- done_sig  out  1  one-cycle pulse when P_filt is updated.
- busy  out  1  high while a sample is being processed.
- overrun  out  1  one-cycle pulse when sta arrives while busy.

Behaviour:
- Reset: when rst==0 at a clk edge, P_filt=Y_INIT, done_sig=0, busy=0, overrun=0, FSM=IDLE, and cycle counter=0.
- Reset: the arithmetic cores' aclr is driven high from a registered ~rst. Any in-flight core result is discarded, because the FSM is back in IDLE and ignores core outputs.
- Arithmetic: all values are IEEE-754 single, computed by the team's adder and multiplier cores with clk_en=`ena_math.
- Arithmetic: no local rounding or width change. NaN and Inf propagate as the cores produce them.
- FSM IDLE: busy=0.
  - On sta=1, latch P into p_reg, launch subtraction p_reg - P_filt (add_sub=`sub), load counter=ADD_LAT-1, go to SUB.
  - On clr=1 with sta=0, load P_filt=Y_INIT. If clr and sta are both high, sta wins and clr is ignored.
- FSM SUB: wait until counter==0, then capture diff, launch the multiply K_COEF*diff, load counter=MUL_LAT-1, go to MUL.
- FSM MUL: wait until counter==0, then capture prod, launch the add P_filt+prod (add_sub=`add), load counter=ADD_LAT-1, go to ADD.
- FSM ADD: when counter==0, register the adder result into P_filt, pulse done_sig in the same cycle, go to IDLE.
- Latency: sta at cycle 0 gives done_sig and the new P_filt at cycle 2*ADD_LAT+MUL_LAT = 19 with defaults, plus one cycle for each capture register. The exact figure is fixed by implementation and documented as LAT_TOTAL. The bench checks LAT_TOTAL is constant across samples.
- Throughput: one sample per LAT_TOTAL+1 cycles. The FSM may accept a new sta on the cycle after done_sig.
- Busy/overrun: busy=1 in SUB, MUL and ADD. A sta arriving while busy=1 is dropped: P_filt is unaffected and overrun pulses for one cycle.
- Back-to-back: sta in the same cycle as done_sig counts as busy and is dropped with overrun.
- Hold: P_filt changes only in the ADD-completion cycle, on clr in IDLE, or on reset. P is sampled only at the accepted sta. Later changes on P do not affect the computation.
- Core inputs: operand registers hold stable for the whole wait period of each operation.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release -> P_filt=0x00000000, done_sig/busy/overrun all 0 for 50 cycles with sta=0.
- Basic step with K_COEF=0x3F000000 (0.5):
  - P=0x40800000 (4.0), single sta -> exactly one done_sig at LAT_TOTAL, P_filt=0x40000000 (2.0).
  - Second sta with P=4.0 -> P_filt=0x40400000 (3.0).
  - Third sta with P=4.0 -> 0x40600000 (3.5).
- Overrun: issue sta, then a second sta 5 cycles later with P=0x41200000 (10.0) -> overrun pulses once, and only one done_sig occurs. The result reflects the first sample only.
- Clear priority:
  - clr in IDLE -> P_filt=Y_INIT next cycle.
  - clr during busy -> ignored.
  - clr and sta in the same cycle -> sample processed and clr ignored.
- Reset mid-operation: with sta accepted, drop rst for one cycle at cycle 8 -> P_filt=Y_INIT, busy=0, no done_sig afterwards. A new sta after release completes normally with the correct value.
- Default K soak: 200 samples of P=1000.0 at the minimum legal spacing -> P_filt rises monotonically, stays within 1 ulp-scaled tolerance of a reference model, and shows no overrun.

Source files
------------

// File: rtl/p_lpf_iir.sv
// First-order low-pass filter on single-precision power samples: y += K*(P - y),
// sequenced by an FSM around one pipelined float adder and one float multiplier.
module p_lpf_iir #(
   parameter logic [31:0] K_COEF  = 32'h3D4CCCCD,
   parameter logic [31:0] Y_INIT  = 32'h00000000,
   parameter int unsigned ADD_LAT = 7,
   parameter int unsigned MUL_LAT = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sta,
   input  logic        clr,
   input  logic [31:0] P,
   output logic [31:0] P_filt,
   output logic        done_sig,
   output logic        busy,
   output logic        overrun
);

   localparam logic        ENA_MATH = 1'b1;
   localparam logic [31:0] QNAN     = 32'h7FC00000;
   localparam int unsigned MAX_LAT  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
   localparam int unsigned CW       = $clog2(MAX_LAT) + 1;

   typedef enum logic [1:0] {IDLE, SUB, MUL, ADD} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   opa, opb, diff;
   logic          op_sub;
   logic          aclr;
   logic [31:0]   add_pipe [ADD_LAT-1];
   logic [31:0]   mul_pipe [MUL_LAT-1];
   logic [31:0]   add_res, mul_res;

   // m carries 24 significant bits plus guard, round and sticky; round-to-nearest-even.
   function automatic logic [31:0] round_pack(input logic s, input int e, input logic [26:0] m);
      logic [24:0] r;
      int          eo;
      eo = e;
      r  = {1'b0, m[26:3]} + 25'(m[2] & (m[1] | m[0] | m[3]));
      if (r[24]) begin
         r  = r >> 1;
         eo = eo + 1;
      end
      if (eo <= 0)   return {s, 31'h0};
      if (eo >= 255) return {s, 8'hFF, 23'h0};
      return {s, eo[7:0], r[22:0]};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [26:0] mx, ys, m;
      logic [50:0] wide;
      logic [27:0] s28;
      int          e, d, lz;
      if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0)) return QNAN;
      if (a[30:23] == 8'hFF) return (b[30:23] == 8'hFF && a[31] != b[31]) ? QNAN : a;
      if (b[30:23] == 8'hFF) return b;
      if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? {a[31] & b[31], 31'h0} : b;
      if (b[30:23] == 8'h00) return a;
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      e    = int'(x[30:23]);
      d    = int'(x[30:23]) - int'(y[30:23]);
      mx   = {1'b1, x[22:0], 3'b000};
      wide = {1'b1, y[22:0], 27'h0};
      if (d > 50) begin
         ys = 27'h1;
      end else begin
         wide = wide >> d;
         ys   = {wide[50:25], wide[24] | (|wide[23:0])};
      end
      if (x[31] == y[31]) begin
         s28 = {1'b0, mx} + {1'b0, ys};
         if (s28[27]) begin
            m = {s28[27:2], s28[1] | s28[0]};
            e = e + 1;
         end else begin
            m = s28[26:0];
         end
      end else begin
         m = mx - ys;
         if (m == '0) return '0;
         lz = 0;
         for (int unsigned i = 0; i < 27; i++)
            if (m[i]) lz = 26 - int'(i);
         m = m << lz;
         e = e - lz;
      end
      return round_pack(x[31], e, m);
   endfunction

   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [47:0] p;
      int          e;
      s = a[31] ^ b[31];
      if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0)) return QNAN;
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
         return (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? QNAN : {s, 8'hFF, 23'h0};
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) e = e + 1;
      else       p = p << 1;
      return round_pack(s, e, {p[47:22], |p[21:0]});
   endfunction

   always_ff @(posedge clk)
      aclr <= ~rst;

   // The operand register counts as the first stage, so the cores hold LAT-1 internal stages.
   always_ff @(posedge clk) begin
      if (aclr) begin
         for (int unsigned i = 0; i < ADD_LAT - 1; i++) add_pipe[i] <= '0;
      end else if (ENA_MATH) begin
         add_pipe[0] <= fp_add(opa, {opb[31] ^ op_sub, opb[30:0]});
         for (int unsigned i = 1; i < ADD_LAT - 1; i++) add_pipe[i] <= add_pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (aclr) begin
         for (int unsigned i = 0; i < MUL_LAT - 1; i++) mul_pipe[i] <= '0;
      end else if (ENA_MATH) begin
         mul_pipe[0] <= fp_mul(K_COEF, diff);
         for (int unsigned i = 1; i < MUL_LAT - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
      end
   end

   assign add_res = add_pipe[ADD_LAT-2];
   assign mul_res = mul_pipe[MUL_LAT-2];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         opa      <= '0;
         opb      <= '0;
         op_sub   <= 1'b0;
         diff     <= '0;
         P_filt   <= Y_INIT;
         done_sig <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         done_sig <= 1'b0;
         overrun  <= 1'b0;
         if (cnt != '0) cnt <= cnt - CW'(1);
         case (state)
            IDLE: begin
               // The done cycle still counts as busy for an incoming strobe.
               if (sta && done_sig) begin
                  overrun <= 1'b1;
               end else if (sta) begin
                  opa    <= P;
                  opb    <= P_filt;
                  op_sub <= 1'b1;
                  cnt    <= CW'(ADD_LAT - 1);
                  busy   <= 1'b1;
                  state  <= SUB;
               end else if (clr) begin
                  P_filt <= Y_INIT;
               end
            end
            SUB: begin
               if (sta) overrun <= 1'b1;
               if (cnt == '0) begin
                  diff  <= add_res;
                  cnt   <= CW'(MUL_LAT - 1);
                  state <= MUL;
               end
            end
            MUL: begin
               if (sta) overrun <= 1'b1;
               if (cnt == '0) begin
                  opa    <= P_filt;
                  opb    <= mul_res;
                  op_sub <= 1'b0;
                  cnt    <= CW'(ADD_LAT - 1);
                  state  <= ADD;
               end
            end
            ADD: begin
               if (sta) overrun <= 1'b1;
               if (cnt == '0) begin
                  P_filt   <= add_res;
                  done_sig <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_p_lpf_iir.sv
// Directed bench for p_lpf_iir: one instance with K=0.5 for exact step values,
// one with the default K for a long convergence run against a real-valued model.
module tb_p_lpf_iir;

   localparam int LAT_TOTAL = 20;

   logic        clk = 1'b0;
   logic        rst, sta, clr;
   logic [31:0] P;
   logic [31:0] h_pf, d_pf;
   logic        h_done, h_busy, h_ovr;
   logic        d_done, d_busy, d_ovr;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   p_lpf_iir #(.K_COEF(32'h3F000000)) dut_h (
      .clk(clk), .rst(rst), .sta(sta), .clr(clr), .P(P),
      .P_filt(h_pf), .done_sig(h_done), .busy(h_busy), .overrun(h_ovr)
   );

   p_lpf_iir dut_d (
      .clk(clk), .rst(rst), .sta(sta), .clr(clr), .P(P),
      .P_filt(d_pf), .done_sig(d_done), .busy(d_busy), .overrun(d_ovr)
   );

   function automatic real bits2real(input logic [31:0] b);
      int  e;
      real m;
      e = int'(b[30:23]);
      if (e == 0) return 0.0;
      m = 1.0 + real'(b[22:0]) / 8388608.0;
      e = e - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      if (b[31]) m = -m;
      return m;
   endfunction

   // Drives one strobe, then returns at the negedge where done_sig is seen (lat=-1 on timeout).
   task automatic run_sample(input logic [31:0] p, input logic clr_with, input int extra_at,
                             input logic clr_busy, output int lat, output int novr);
      lat  = -1;
      novr = 0;
      sta  = 1'b1;
      P    = p;
      clr  = clr_with;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (h_ovr) novr++;
         if (h_done) begin
            lat = c;
            break;
         end
         sta = (c == extra_at);
         P   = (c == extra_at) ? 32'h41200000 : (32'h7F800000 ^ 32'(c));
         clr = clr_busy && (c < 15);
      end
      sta = 1'b0;
      clr = 1'b0;
   endtask

   task automatic count_extra_done(input string name);
      int n = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (h_done) n++;
      end
      vecs++;
      if (n !== 0) begin
         errs++;
         $display("FAIL %s: extra done pulses got %0d want 0", name, n);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; sta = 1'b0; clr = 1'b0; P = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vecs++;
      if (h_pf !== 32'h0 || d_pf !== 32'h0) begin
         errs++;
         $display("FAIL reset_pf: got %h/%h want 00000000", h_pf, d_pf);
      end
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         vecs++;
         if ({h_done, h_busy, h_ovr} !== 3'b000) begin
            errs++;
            $display("FAIL reset_idle: cycle %0d done/busy/ovr got %b want 000", c, {h_done, h_busy, h_ovr});
         end
      end
   endtask

   task automatic test_step;
      logic [31:0] exp_v [3] = '{32'h40000000, 32'h40400000, 32'h40600000};
      int lat, novr;
      for (int i = 0; i < 3; i++) begin
         run_sample(32'h40800000, 1'b0, 0, 1'b0, lat, novr);
         vecs++;
         if (lat !== LAT_TOTAL) begin
            errs++;
            $display("FAIL step_lat: sample %0d got %0d want %0d", i, lat, LAT_TOTAL);
         end
         vecs++;
         if (h_pf !== exp_v[i]) begin
            errs++;
            $display("FAIL step_val: sample %0d got %h want %h", i, h_pf, exp_v[i]);
         end
         count_extra_done("step_once");
      end
   endtask

   task automatic test_clear;
      int lat, novr;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      vecs++;
      if (h_pf !== 32'h0) begin
         errs++;
         $display("FAIL clr_idle: got %h want 00000000", h_pf);
      end
      run_sample(32'h40800000, 1'b0, 0, 1'b0, lat, novr);
      vecs++;
      if (h_pf !== 32'h40000000) begin
         errs++;
         $display("FAIL clr_restart: got %h want 40000000", h_pf);
      end
      @(negedge clk);
      run_sample(32'h40800000, 1'b0, 0, 1'b1, lat, novr);
      repeat (3) @(negedge clk);
      vecs++;
      if (h_pf !== 32'h40400000) begin
         errs++;
         $display("FAIL clr_busy: got %h want 40400000", h_pf);
      end
      run_sample(32'h40800000, 1'b1, 0, 1'b0, lat, novr);
      vecs++;
      if (h_pf !== 32'h40600000 || lat !== LAT_TOTAL) begin
         errs++;
         $display("FAIL clr_with_sta: got %h lat %0d want 40600000 lat %0d", h_pf, lat, LAT_TOTAL);
      end
   endtask

   task automatic test_overrun;
      int lat, novr;
      @(negedge clk);
      run_sample(32'h40800000, 1'b0, 5, 1'b0, lat, novr);
      vecs++;
      if (novr !== 1) begin
         errs++;
         $display("FAIL ovr_count: got %0d want 1", novr);
      end
      vecs++;
      if (h_pf !== 32'h40700000 || lat !== LAT_TOTAL) begin
         errs++;
         $display("FAIL ovr_val: got %h lat %0d want 40700000 lat %0d", h_pf, lat, LAT_TOTAL);
      end
      count_extra_done("ovr_once");
   endtask

   task automatic test_back_to_back;
      int lat, novr;
      run_sample(32'h40800000, 1'b0, 0, 1'b0, lat, novr);
      vecs++;
      if (h_pf !== 32'h40780000) begin
         errs++;
         $display("FAIL b2b_first: got %h want 40780000", h_pf);
      end
      sta = 1'b1;
      P   = 32'h41200000;
      @(negedge clk);
      sta = 1'b0;
      vecs++;
      if ({h_ovr, h_busy} !== 2'b10 || h_pf !== 32'h40780000) begin
         errs++;
         $display("FAIL b2b_drop: ovr/busy got %b pf %h want 10 pf 40780000", {h_ovr, h_busy}, h_pf);
      end
      run_sample(32'h40800000, 1'b0, 0, 1'b0, lat, novr);
      vecs++;
      if (h_pf !== 32'h407C0000 || lat !== LAT_TOTAL || novr !== 0) begin
         errs++;
         $display("FAIL b2b_next: got %h lat %0d ovr %0d want 407c0000 lat %0d ovr 0", h_pf, lat, novr, LAT_TOTAL);
      end
   endtask

   task automatic test_reset_mid;
      int lat, novr;
      int ndone = 0;
      @(negedge clk);
      sta = 1'b1;
      P   = 32'h40800000;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         if (h_done) ndone++;
         if (c == 9) begin
            vecs++;
            if (h_pf !== 32'h0 || h_busy !== 1'b0) begin
               errs++;
               $display("FAIL rstmid_state: pf %h busy %b want 00000000 0", h_pf, h_busy);
            end
         end
         sta = 1'b0;
         P   = 32'h7F800000 ^ 32'(c);
         rst = (c == 8) ? 1'b0 : 1'b1;
      end
      vecs++;
      if (ndone !== 0) begin
         errs++;
         $display("FAIL rstmid_nodone: got %0d want 0", ndone);
      end
      run_sample(32'h40800000, 1'b0, 0, 1'b0, lat, novr);
      vecs++;
      if (h_pf !== 32'h40000000 || lat !== LAT_TOTAL) begin
         errs++;
         $display("FAIL rstmid_after: got %h lat %0d want 40000000 lat %0d", h_pf, lat, LAT_TOTAL);
      end
   endtask

   task automatic test_soak;
      int          lat, novr;
      real         y, k, err;
      logic [31:0] prev;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      vecs++;
      if (d_pf !== 32'h0) begin
         errs++;
         $display("FAIL soak_clr: got %h want 00000000", d_pf);
      end
      k    = bits2real(32'h3D4CCCCD);
      y    = 0.0;
      prev = 32'h0;
      for (int n = 0; n < 200; n++) begin
         run_sample(32'h447A0000, 1'b0, 0, 1'b0, lat, novr);
         vecs++;
         if (lat !== LAT_TOTAL || novr !== 0 || {d_done, d_busy, d_ovr} !== 3'b100) begin
            errs++;
            $display("FAIL soak_timing: n %0d lat %0d ovr %0d flags %b want lat %0d ovr 0 flags 100",
                     n, lat, novr, {d_done, d_busy, d_ovr}, LAT_TOTAL);
         end
         y   = y + k * (1000.0 - y);
         err = bits2real(d_pf) - y;
         if (err < 0.0) err = -err;
         vecs++;
         if (err > 0.01) begin
            errs++;
            $display("FAIL soak_model: n %0d got %h (%f) want %f", n, d_pf, bits2real(d_pf), y);
         end
         vecs++;
         if (!(d_pf > prev)) begin
            errs++;
            $display("FAIL soak_mono: n %0d got %h want above %h", n, d_pf, prev);
         end
         prev = d_pf;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset;
      test_step;
      test_clear;
      test_overrun;
      test_back_to_back;
      test_reset_mid;
      test_soak;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
